// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory request arbiter.
// The state encoding is also exported on the debug port for external checkers.
package mem_rr_arbiter_pkg;

    localparam int ARB_N      = 8;
    localparam int ARB_AW     = 8;
    localparam int ARB_DW     = 8;
    localparam int ARB_RD_LAT = 1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RWAIT  = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    // The next priority position wraps from the last core back to core 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Bundle that carries the core request bus and the single-port RAM port.
// The request side and the RAM side meet at the arbiter.
interface mem_rr_arbiter_if
    import mem_rr_arbiter_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    // Handshake: core i holds rden[i]/wren[i] (plus Address/Din) as a level until it
    // samples acq[i]=1, and drops the request on that same edge. If both are high,
    // the request is a write. Dq slice i is valid in the acq cycle.
    logic [N-1:0]    rden;
    logic [N-1:0]    wren;
    logic [N*AW-1:0] Address;
    logic [N*DW-1:0] Din;
    logic [N-1:0]    acq;
    logic [N*DW-1:0] Dq;
    logic [AW-1:0]   RAMAddress;
    logic [DW-1:0]   RAMDin;
    logic            RAMwren;
    logic [DW-1:0]   RAMq;
    logic            busy;

    modport slave (
        input  rden, wren, Address, Din, RAMq,
        output acq, Dq, RAMAddress, RAMDin, RAMwren, busy
    );

    modport master (
        output rden, wren, Address, Din, RAMq,
        input  acq, Dq, RAMAddress, RAMDin, RAMwren, busy
    );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first requester found
// when searching from ptr_i upward, wrapping at N.
module mem_rr_arbiter_rr_pick
    import mem_rr_arbiter_pkg::*;
#(
    parameter  int N  = ARB_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Bit k of rot is the request of core (ptr_i + k) mod N.
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[N-1:0];

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && rot[k]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Serialises read/write requests from N cores onto one synchronous single-port RAM
// with round-robin fairness, a one-cycle acq pulse and a per-core read data bank.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter  int N      = ARB_N,
    parameter  int AW     = ARB_AW,
    parameter  int DW     = ARB_DW,
    parameter  int RD_LAT = ARB_RD_LAT,
    localparam int IW     = $clog2(N)
) (
    input  logic               CLK,
    input  logic               rst,
    mem_rr_arbiter_if.slave    bus,
    output arb_state_e         dbg_state_o,
    output logic [IW-1:0]      dbg_ptr_o
);

    arb_state_e      state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gnt_q;
    logic            op_wr_q;
    logic [1:0]      cnt_q;
    logic [N-1:0]    acq_q;
    logic [DW-1:0]   dq_q [N];
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_din_q;
    logic            ram_wren_q;

    logic [N-1:0]    pending;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    gnt_onehot;
    logic [AW-1:0]   addr_a [N];
    logic [DW-1:0]   din_a  [N];

    assign pending    = bus.rden | bus.wren;
    assign gnt_onehot = N'(1) << gnt_q;

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign addr_a[g]             = bus.Address[g*AW +: AW];
        assign din_a[g]              = bus.Din[g*DW +: DW];
        assign bus.Dq[g*DW +: DW]    = dq_q[g];
    end

    mem_rr_arbiter_rr_pick #(.N(N)) u_pick (
        .req_i   (pending),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            op_wr_q    <= 1'b0;
            cnt_q      <= '0;
            acq_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wren_q <= 1'b0;
            for (int i = 0; i < N; i++) dq_q[i] <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_idx;
                        ram_addr_q <= addr_a[pick_idx];
                        ram_din_q  <= din_a[pick_idx];
                        op_wr_q    <= bus.wren[pick_idx];
                        ram_wren_q <= bus.wren[pick_idx];
                        state_q    <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    ram_wren_q <= 1'b0;
                    if (op_wr_q) begin
                        acq_q   <= gnt_onehot;
                        state_q <= ARB_DONE;
                    end else begin
                        cnt_q   <= 2'(RD_LAT - 1);
                        state_q <= ARB_RWAIT;
                    end
                end
                ARB_RWAIT: begin
                    // RAMq is captured in the last wait cycle so Dq is ready with acq.
                    if (cnt_q == 2'd0) begin
                        dq_q[gnt_q] <= bus.RAMq;
                        acq_q       <= gnt_onehot;
                        state_q     <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ARB_DONE: begin
                    acq_q   <= '0;
                    ptr_q   <= IW'(rr_next(int'(gnt_q), N));
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.acq        = acq_q;
    assign bus.RAMAddress = ram_addr_q;
    assign bus.RAMDin     = ram_din_q;
    assign bus.RAMwren    = ram_wren_q;
    assign bus.busy       = (state_q != ARB_IDLE);
    assign dbg_state_o    = state_q;
    assign dbg_ptr_o      = ptr_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random request rounds, checked by
// a scoreboard fed from a rotating-priority service model.
module tb_mem_rr_arbiter;
    import mem_rr_arbiter_pkg::*;

    localparam int N      = 8;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int IW     = 3;
    localparam int EW     = 44;   // {acq cycle[31:0], is_write, core[2:0], data[7:0]}

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic rst;
    logic ram_clr;
    always #5 CLK = ~CLK;

    mem_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();
    arb_state_e    dbg_state;
    logic [IW-1:0] dbg_ptr;

    mem_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    int cyc;
    always @(posedge CLK) begin
        if (ram_clr) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Synchronous single-port RAM, one cycle read latency, read-before-write.
    logic [DW-1:0] ram_mem [256];
    always @(posedge CLK) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (bus.RAMwren) begin
            ram_mem[bus.RAMAddress] <= bus.RAMDin;
        end
        bus.RAMq <= ram_mem[bus.RAMAddress];
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q [$];
    logic [15:0]   wr_q  [$];
    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [256];
    int            model_ptr;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_din  [N];

    function automatic logic [IW-1:0] ix(input int v);
        return IW'(v % N);
    endfunction

    // Service order: repeatedly take the first pending core at or after ptr.
    // Each entry's acq cycle follows from the latency rules, measured from the
    // cycle in which the requests are presented to an idle arbiter.
    task automatic plan_round(input logic [N-1:0] rd, input logic [N-1:0] wr, input int t0);
        logic [N-1:0]  pend;
        logic [DW-1:0] d;
        logic          is_wr;
        int            p, t, win, lat;
        bit            first;
        pend  = rd | wr;
        p     = model_ptr;
        t     = t0;
        first = 1'b1;
        while (pend != '0) begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && pend[ix(p + k)]) win = (p + k) % N;
            is_wr = wr[ix(win)];
            lat   = is_wr ? 2 : 2 + RD_LAT;
            t     = first ? t + lat : t + 1 + lat;
            first = 1'b0;
            if (is_wr) begin
                ref_mem[r_addr[ix(win)]] = r_din[ix(win)];
                wr_q.push_back({r_addr[ix(win)], r_din[ix(win)]});
                d = r_din[ix(win)];
            end else begin
                d = ref_mem[r_addr[ix(win)]];
            end
            exp_q.push_back({t[31:0], is_wr, ix(win), d});
            pend[ix(win)] = 1'b0;
            p = (win + 1) % N;
        end
        model_ptr = p;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bus(input logic [N-1:0] rd, input logic [N-1:0] wr);
        logic [N*AW-1:0] av;
        logic [N*DW-1:0] dv;
        for (int i = 0; i < N; i++) begin
            av[i*AW +: AW] = r_addr[i];
            dv[i*DW +: DW] = r_din[i];
        end
        bus.Address = av;
        bus.Din     = dv;
        bus.rden    = rd;
        bus.wren    = wr;
    endtask

    task automatic run_round(input logic [N-1:0] rd, input logic [N-1:0] wr);
        int budget;
        @(negedge CLK);
        plan_round(rd, wr, cyc);
        drive_bus(rd, wr);
        budget = 0;
        while (budget < 200 && (bus.rden | bus.wren) != '0) begin
            @(negedge CLK);
            bus.rden = bus.rden & ~bus.acq;
            bus.wren = bus.wren & ~bus.acq;
            budget++;
        end
        chk("round_complete", 64'(bus.rden | bus.wren), 64'(0));
        @(negedge CLK);
        chk("busy_after_round", 64'(bus.busy), 64'(0));
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        bus.rden = '0;
        bus.wren = '0;
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic pulse_rst();
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        #2 rst = 1'b0;
        model_ptr = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [DW-1:0]   mon_dq [N];
        logic            prev_wren;
        logic [EW-1:0]   e;
        logic [15:0]     w;
        logic [N*DW-1:0] dqv;
        logic [N-1:0]    one_n;
        one_n     = 1;
        prev_wren = 1'b0;
        for (int i = 0; i < N; i++) mon_dq[i] = '0;
        forever begin
            @(negedge CLK);
            if (rst) begin
                for (int i = 0; i < N; i++) mon_dq[i] = '0;
                prev_wren = 1'b0;
            end else begin
                if (bus.RAMwren) begin
                    chk("ramwren_one_cycle", 64'(prev_wren), 64'(0));
                    if (wr_q.size() == 0) begin
                        chk("ramwren_unexpected", 64'(1), 64'(0));
                    end else begin
                        w = wr_q.pop_front();
                        chk("ram_address", 64'(bus.RAMAddress), 64'(w[15:8]));
                        chk("ram_din", 64'(bus.RAMDin), 64'(w[7:0]));
                    end
                end
                prev_wren = bus.RAMwren;
                if (bus.acq != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("acq_unexpected", 64'(bus.acq), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("acq_core", 64'(bus.acq), 64'(one_n << e[10:8]));
                        chk("acq_cycle", 64'(cyc), 64'(e[43:12]));
                        chk("busy_in_done", 64'(bus.busy), 64'(1));
                        if (!e[11]) mon_dq[e[10:8]] = e[7:0];
                        for (int i = 0; i < N; i++) dqv[i*DW +: DW] = mon_dq[i];
                        chk("dq_bank", 64'(bus.Dq), 64'(dqv));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] rd, wr;
        int unsigned  r;
        rst      = 1'b1;
        ram_clr  = 1'b1;
        bus.rden = '0;
        bus.wren = '0;
        bus.Address = '0;
        bus.Din  = '0;
        model_ptr = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_din[i] = '0; end
        repeat (3) @(negedge CLK);
        chk("rst_acq", 64'(bus.acq), 64'(0));
        chk("rst_dq", 64'(bus.Dq), 64'(0));
        chk("rst_ramaddress", 64'(bus.RAMAddress), 64'(0));
        chk("rst_ramdin", 64'(bus.RAMDin), 64'(0));
        chk("rst_ramwren", 64'(bus.RAMwren), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        chk("rst_ptr", 64'(dbg_ptr), 64'(0));
        #2;
        rst     = 1'b0;
        ram_clr = 1'b0;

        // Write by core 2, then read back by core 5.
        r_addr[2] = 8'h10; r_din[2] = 8'hA5;
        run_round(8'h00, 8'h04);
        r_addr[5] = 8'h10;
        run_round(8'h20, 8'h00);

        // All cores read together right after reset: order 0..7.
        pulse_rst();
        for (int i = 0; i < N; i++) r_addr[i] = 8'h10;
        r_addr[3] = 8'h11;
        run_round(8'hFF, 8'h00);

        // Core 3 served leaves ptr at 4, so core 6 beats core 1.
        run_round(8'h08, 8'h00);
        run_round(8'h42, 8'h00);

        // rden and wren together count as a write.
        r_addr[0] = 8'h20; r_din[0] = 8'h3C;
        run_round(8'h01, 8'h01);
        r_addr[7] = 8'h20;
        run_round(8'h80, 8'h00);

        // Reset during the ACCESS cycle of a write aborts it.
        @(negedge CLK);
        r_addr[4] = 8'h30; r_din[4] = 8'h77;
        drive_bus(8'h00, 8'h10);
        wr_q.push_back({8'h30, 8'h77});
        @(negedge CLK);
        #3;
        chk("abort_wren_in_access", 64'(bus.RAMwren), 64'(1));
        rst = 1'b1;
        #1;
        chk("abort_ramwren", 64'(bus.RAMwren), 64'(0));
        chk("abort_acq", 64'(bus.acq), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_state", 64'(dbg_state), 64'(ARB_IDLE));
        chk("abort_ptr", 64'(dbg_ptr), 64'(0));
        bus.wren = '0;
        wr_q.delete();
        model_ptr = 0;
        @(negedge CLK);
        #2 rst = 1'b0;
        r_addr[0] = 8'h20; r_addr[5] = 8'h30;
        run_round(8'h21, 8'h00);

        // Random rounds over a small address range so reads and writes collide.
        for (int n = 0; n < 40; n++) begin
            rd = '0;
            wr = '0;
            for (int i = 0; i < N; i++) begin
                r         = $urandom_range(0, 3);
                r_addr[i] = 8'($urandom_range(0, 15));
                r_din[i]  = 8'($urandom);
                rd        = (rd << 1) | N'(r[0]);
                wr        = (wr << 1) | N'(r[1]);
            end
            run_round(rd, wr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
